// File: rtl/vec_mem_requester.sv
// vec_mem_requester: splits scalar/vector MEM-stage accesses into word beats.
// Optional watchdog abort enabled by defining VMEM_TIMEOUT_EN.
module vec_mem_requester #(
  parameter int S = 32,
  parameter int V = 192
`ifdef VMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wd,
  output logic         resp_valid,
  output logic [V-1:0] resp_rd,
  output logic         resp_err,
  output logic         stall,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic         mem_rvalid,
  input  logic [S-1:0] mem_rdata
);

  localparam int LANES = V / S;
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] beat, ret, n_q, ret_sum;
  logic          we_q;
  logic [S-1:0]  addr_q;
  logic [V-1:0]  wd_q, rd_buf, rd_nx;
  logic          accept, beat_fire, ret_fire;
  logic          last_beat, busy, to_hit;

  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_valid = (state == ISSUE);
  assign mem_we    = mem_valid && we_q;
  assign beat_fire = mem_valid && mem_ready;
  assign ret_fire  = busy && mem_rvalid && (ret < n_q);
  assign last_beat = beat_fire && (beat == n_q - 1'b1);
  assign ret_sum   = ret + {{(CW-1){1'b0}}, ret_fire};
  assign mem_addr  = addr_q + {{(S-CW){1'b0}}, beat};
  assign mem_wd    = wd_q[beat*S +: S];
  assign resp_valid = (state == DONE);
  assign stall     = (state != IDLE);

`ifdef VMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  assign to_hit = busy && !beat_fire && !ret_fire &&
                  (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign resp_err = (state == DONE) && err_q;

  // Watchdog: counts busy cycles since the last beat or return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy || beat_fire || ret_fire) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      if (to_hit) err_q <= 1'b1;
      else if (state == DONE) err_q <= 1'b0;
    end
  end
`else
  assign to_hit   = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Next state: issue beats, drain outstanding reads, one-cycle done.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: begin
        if (to_hit) state_nx = DONE;
        else if (last_beat) begin
          if (we_q || ret_sum >= n_q) state_nx = DONE;
          else state_nx = DRAIN;
        end
      end
      DRAIN: if (to_hit || ret_sum >= n_q) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Merge the current read return into the assembly buffer.
  always_comb begin
    rd_nx = rd_buf;
    if (ret_fire) rd_nx[ret*S +: S] = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  // Request latch, beat/return counters and read reassembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      n_q    <= '0;
      beat   <= '0;
      ret    <= '0;
      rd_buf <= '0;
      resp_rd <= '0;
    end else begin
      if (accept) begin
        we_q   <= req_we;
        addr_q <= req_addr;
        wd_q   <= req_wd;
        n_q    <= req_vec ? CW'(LANES) : CW'(1);
        beat   <= '0;
        ret    <= '0;
        rd_buf <= '0;
      end else begin
        if (beat_fire) beat <= beat + 1'b1;
        if (ret_fire) ret <= ret + 1'b1;
        rd_buf <= rd_nx;
      end
      if (busy && state_nx == DONE && !we_q && !to_hit)
        resp_rd <= rd_nx;
    end
  end

endmodule

// File: tb/tb_vec_mem_requester.sv
// tb_vec_mem_requester: scoreboard bench with a word-memory responder.
// Define VMEM_TIMEOUT_EN to also exercise the watchdog abort.
module tb_vec_mem_requester;

  localparam int S = 32;
  localparam int V = 192;
  localparam int L = V / S;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic         req_vec = 1'b0;
  logic [S-1:0] req_addr = '0;
  logic [V-1:0] req_wd = '0;
  logic         resp_valid;
  logic [V-1:0] resp_rd;
  logic         resp_err;
  logic         stall;
  logic         mem_valid;
  logic         mem_ready = 1'b1;
  logic         mem_we;
  logic [S-1:0] mem_addr;
  logic [S-1:0] mem_wd;
  logic         mem_rvalid = 1'b0;
  logic [S-1:0] mem_rdata = '0;

  vec_mem_requester dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rd(resp_rd),
    .resp_err(resp_err), .stall(stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [S-1:0] addr;
    logic         we;
    logic [S-1:0] wd;
  } beat_t;

  typedef struct {
    logic [V-1:0] rd;
    logic         err;
    int           lat;
  } rsp_t;

  beat_t        exp_b[$];
  rsp_t         exp_r[$];
  logic [S-1:0] pend[$];
  logic [S-1:0] mem[logic [S-1:0]];
  logic [V-1:0] last_rd = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_resp = 0;
  int beats_seen = 0;
  int ready_mode = 0;
  logic         held = 1'b0;
  logic [S-1:0] hold_a = '0;
  logic [S-1:0] hold_d = '0;

  task automatic chk(input string tag, input logic [V-1:0] got,
                     input logic [V-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [S-1:0] rd_mem(input logic [S-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder and output monitor, all on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (pend.size() > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ~mem_ready;
      2: mem_ready = 1'b0;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
    if (held)
      chk("beat_hold", V'({mem_valid, mem_addr, mem_wd}),
          V'({1'b1, hold_a, hold_d}));
    held   = mem_valid && !mem_ready && ready_mode != 2;
    hold_a = mem_addr;
    hold_d = mem_wd;
    if (mem_valid && mem_ready) begin
      beats_seen++;
      if (exp_b.size() == 0) begin
        chk("beat_unexp", V'(exp_b.size()), V'(1));
      end else begin
        b = exp_b.pop_front();
        chk("beat_addr", V'(mem_addr), V'(b.addr));
        chk("beat_we", V'(mem_we), V'(b.we));
        if (b.we) chk("beat_wd", V'(mem_wd), V'(b.wd));
      end
      if (mem_we) mem[mem_addr] = mem_wd;
      else pend.push_back(rd_mem(mem_addr));
    end
    if (resp_valid) begin
      n_resp++;
      if (exp_r.size() == 0) begin
        chk("resp_unexp", V'(exp_r.size()), V'(1));
      end else begin
        r = exp_r.pop_front();
        chk("resp_rd", resp_rd, r.rd);
        chk("resp_err", V'(resp_err), V'(r.err));
        chk("resp_stall", V'(stall), V'(1));
        if (r.lat >= 0)
          chk("resp_lat", V'(cyc + 1 - acc_cyc), V'(r.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic vec,
                       input logic [S-1:0] a, input logic [V-1:0] wd,
                       input int lat, input logic err);
    int n;
    int g;
    logic [V-1:0] rd;
    beat_t b;
    rsp_t r;
    n  = vec ? L : 1;
    rd = '0;
    for (int k = 0; k < n; k++) begin
      b.addr = a + S'(k);
      b.we   = we;
      b.wd   = wd[k*S +: S];
      if (!err) exp_b.push_back(b);
      rd[k*S +: S] = rd_mem(a + S'(k));
    end
    r.rd  = (we || err) ? last_rd : rd;
    r.err = err;
    r.lat = lat;
    if (!we && !err) last_rd = rd;
    exp_r.push_back(r);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_vec   = vec;
    req_addr  = a;
    req_wd    = wd;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready", V'(req_ready), V'(1));
    acc_cyc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall_busy", V'(stall), V'(1));
  endtask

  task automatic run(input logic we, input logic vec,
                     input logic [S-1:0] a, input logic [V-1:0] wd,
                     input int lat, input logic err);
    int r0;
    int g;
    r0 = n_resp;
    issue(we, vec, a, wd, lat, err);
    g = 0;
    while (n_resp == r0 && g < 300) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("resp_seen", V'(n_resp - r0), V'(1));
    @(negedge clk);
    #1;
    chk("idle_stall", V'({stall, req_ready}), V'(2'b01));
  endtask

  initial begin
    int r0;
    int b0;
    int g;
    logic [V-1:0] wd;
    for (int i = 0; i < L; i++) mem[32'h1F4 + i] = 32'hA0 + i;
    mem[32'h40] = 32'hDEADBEEF;

    #12;
    chk("rst_outs", V'({resp_valid, resp_err, mem_valid, mem_we, stall}),
        V'(5'b0));
    chk("rst_rd", resp_rd, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", V'(req_ready), V'(1));

    for (int i = 0; i < L; i++) wd[i*S +: S] = S'(i + 1);
    run(1'b1, 1'b1, 32'h320, wd, 7, 1'b0);
    run(1'b0, 1'b1, 32'h1F4, '0, 8, 1'b0);

    ready_mode = 1;
    run(1'b0, 1'b0, 32'h40, '0, -1, 1'b0);
    chk("scalar_fill", resp_rd, {160'b0, 32'hDEADBEEF});
    ready_mode = 0;
    run(1'b1, 1'b0, 32'h88, {160'b0, 32'h12345678}, 2, 1'b0);
    chk("store_keeps_rd", resp_rd, {160'b0, 32'hDEADBEEF});
    run(1'b0, 1'b0, 32'h88, '0, 3, 1'b0);

    r0 = n_resp;
    b0 = beats_seen;
    issue(1'b0, 1'b1, 32'h500, '0, -1, 1'b0);
    g = 0;
    while (beats_seen - b0 < 3 && g < 40) begin
      @(negedge clk);
      #1;
      g++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_outs", V'({mem_valid, mem_we, stall, resp_valid, req_ready}),
        V'(5'b00001));
    chk("arst_rd", resp_rd, '0);
    exp_b.delete();
    exp_r.delete();
    last_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("arst_no_resp", V'(n_resp), V'(r0));
    run(1'b0, 1'b0, 32'h40, '0, 3, 1'b0);

    for (int i = 0; i < L; i++) wd[i*S +: S] = 32'hC0DE_0000 + S'(i);
    run(1'b1, 1'b1, 32'hFFFF_FFFE, wd, 7, 1'b0);
    run(1'b0, 1'b1, 32'hFFFF_FFFE, '0, 8, 1'b0);

    ready_mode = 3;
    for (int t = 0; t < 6; t++) begin
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          S'($urandom_range(0, 255)), wd, -1, 1'b0);
    end
    ready_mode = 0;

`ifdef VMEM_TIMEOUT_EN
    ready_mode = 2;
    run(1'b1, 1'b1, 32'h700, wd, 65, 1'b1);
    ready_mode = 0;
    run(1'b0, 1'b1, 32'h1F4, '0, 8, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("exp_r_empty", V'(exp_r.size()), V'(0));
    chk("exp_b_empty", V'(exp_b.size()), V'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
